benes_route_sequencer: RTL and testbench
========================================

# benes_route_sequencer

Switch-configuration sequencer driving the two Benes networks in the buffer interconnect: R2M (RAM slots to modules) and M2R (modules to RAM slots). It stores a table of precomputed per-stage switch settings, loaded by the host/controller. On command it replays a contiguous run of table entries, one per cycle, onto the interconnect's module-select and slot-select inputs. It also emits a data-valid tag delayed to match the interconnect latency, so downstream logic knows which cycle carries routed data.

## Interface
- SIZE, 32, Benes port count (power of two, ≥4)
- SWITCH_NUM, SIZE/2, 2x2 switches per stage
- STAGE_NUM, 2*log2(SIZE)-1, switch stages (9 at default)
- CFG_DEPTH, 16, table entries (power of two)
- NET_LAT, 4, cycles from select-valid to routed data at interconnect outputs (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_cfg_wr_en  in  1  table write strobe
- i_cfg_wr_tgt  in  1  0 = R2M (module select), 1 = M2R (slot select)
- i_cfg_wr_addr  in  log2(CFG_DEPTH)  table entry
- i_cfg_wr_stage  in  clog2(STAGE_NUM)  stage row within entry
- i_cfg_wr_data  in  SWITCH_NUM  switch bits (1 = cross)
- i_start  in  1  begin replay (honoured in IDLE only)
- i_base  in  log2(CFG_DEPTH)  first entry
- i_len  in  log2(CFG_DEPTH)+1  entries to replay (0..CFG_DEPTH)
- i_hold  in  1  pause replay
- o_module_select  out  [SWITCH_NUM-1:0] x STAGE_NUM  R2M settings
- o_slot_select  out  [SWITCH_NUM-1:0] x STAGE_NUM  M2R settings
- o_sel_valid  out  1  selects carry a new entry this cycle
- o_sel_idx  out  log2(CFG_DEPTH)  entry index on selects
- o_data_valid  out  1  o_sel_valid delayed by NET_LAT
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle completion pulse

## Operation
- Table: two register arrays (R2M, M2R), each CFG_DEPTH x STAGE_NUM x SWITCH_NUM. Reset clears both to all-zero (straight-through). A write updates one stage row of one entry of one target at the clock edge.
- Writes are accepted in every state. A write to the entry being read in the same cycle does not affect that read (old value out); it takes effect on the next read.
- i_cfg_wr_stage ≥ STAGE_NUM: write dropped.
- FSM IDLE → RUN → DRAIN → IDLE.
- IDLE:
  - i_start=1 with i_len≠0: latch ptr=i_base and remaining count=i_len, go to RUN.
  - i_start=1 with i_len=0: go directly to DRAIN with an empty pipe; o_done pulses after NET_LAT cycles.
- RUN, each cycle with i_hold=0: register both table entries[ptr] onto the select outputs, set o_sel_valid=1 and o_sel_idx=ptr, increment ptr mod CFG_DEPTH (wraps 15→0), decrement count. When the last entry is issued, go to DRAIN.
- RUN with i_hold=1: ptr and count frozen, o_sel_valid=0, select outputs hold their last value (switches never glitch).
- DRAIN: wait until the last issued entry's o_data_valid has been emitted, then pulse o_done for one cycle and go to IDLE.
- i_start while busy: ignored.
- Selects keep their last replayed value in IDLE.
- o_data_valid: NET_LAT-deep shift register fed with o_sel_valid.
- Reset mid-operation: FSM to IDLE, shift register cleared, all outputs to reset values, table cleared.

## Timing
- Reset values: all selects 0, o_sel_valid 0, o_sel_idx 0, o_data_valid 0, o_busy 0, o_done 0.
- i_start sampled at edge E0 → o_busy=1 from E0. First o_sel_valid=1 after E1 (select latency 2 edges from start). Unheld run of L entries: o_sel_valid high L consecutive cycles.
- o_data_valid = o_sel_valid exactly NET_LAT cycles later.
- o_done high in the cycle after the last o_data_valid. o_busy falls with the same edge that raises o_done. A new i_start is accepted in the o_done cycle.
- i_hold has effect at the same edge it is sampled.

## Test plan
- Reset check: assert rst_n=0 mid-RUN → all outputs 0 immediately. After release, table reads all-zero: replay base=3, len=1 gives o_module_select all 0.
- Write entry 5 R2M stage 0 = 0xA5A5 and M2R stage 8 = 0x0F0F; start base=5, len=1 → one o_sel_valid with idx=5 and those values, o_data_valid 4 cycles later, o_done the next cycle.
- Wrap: load entries 14, 15, 0 with distinct patterns; start base=14, len=3 → idx sequence 14, 15, 0 on consecutive cycles.
- Hold: len=4, i_hold=1 for 2 cycles after the second entry → sel_valid pattern 1,1,0,0,1,1; selects stable during the hold; data_valid pattern identical, shifted by 4.
- Edge cases: len=0 → no sel_valid, o_done 4 cycles after start. i_start while busy → ignored, idx sequence unaffected.
- Same-cycle write/read: write entry 7 in the cycle ptr=7 is read → old value out. A replay of 7 afterwards shows the new value.

Source files
------------

// File: rtl/benes_route_sequencer_if.sv
// rtl/benes_route_sequencer_if.sv - config-write, replay-command and select bundle of the Benes route sequencer
// Widths derive from SIZE and CFG_DEPTH; the sequencer must be built with the same values.
interface benes_route_sequencer_if #(
    parameter int SIZE      = 32,
    parameter int CFG_DEPTH = 16
);
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int ADDR_W     = $clog2(CFG_DEPTH);
    localparam int STAGE_W    = $clog2(STAGE_NUM);

    logic                                 i_cfg_wr_en;
    logic                                 i_cfg_wr_tgt;
    logic [ADDR_W-1:0]                    i_cfg_wr_addr;
    logic [STAGE_W-1:0]                   i_cfg_wr_stage;
    logic [SWITCH_NUM-1:0]                i_cfg_wr_data;
    logic                                 i_start;
    logic [ADDR_W-1:0]                    i_base;
    logic [ADDR_W:0]                      i_len;
    logic                                 i_hold;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] o_module_select;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] o_slot_select;
    logic                                 o_sel_valid;
    logic [ADDR_W-1:0]                    o_sel_idx;
    logic                                 o_data_valid;
    logic                                 o_busy;
    logic                                 o_done;

    modport master (
        output i_cfg_wr_en, i_cfg_wr_tgt, i_cfg_wr_addr, i_cfg_wr_stage, i_cfg_wr_data,
        output i_start, i_base, i_len, i_hold,
        input  o_module_select, o_slot_select, o_sel_valid, o_sel_idx,
        input  o_data_valid, o_busy, o_done
    );

    modport slave (
        input  i_cfg_wr_en, i_cfg_wr_tgt, i_cfg_wr_addr, i_cfg_wr_stage, i_cfg_wr_data,
        input  i_start, i_base, i_len, i_hold,
        output o_module_select, o_slot_select, o_sel_valid, o_sel_idx,
        output o_data_valid, o_busy, o_done
    );
endinterface

// File: rtl/benes_route_sequencer.sv
// rtl/benes_route_sequencer.sv - replays stored Benes switch settings onto the R2M/M2R select inputs
// Table rows are written by the host; a replay issues one entry per cycle and tags routed data NET_LAT cycles later.
module benes_route_sequencer #(
    parameter int SIZE      = 32,
    parameter int CFG_DEPTH = 16,
    parameter int NET_LAT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    benes_route_sequencer_if.slave bus
);
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int ADDR_W     = $clog2(CFG_DEPTH);
    localparam int STAGE_W    = $clog2(STAGE_NUM);
    localparam int DCNT_W     = $clog2(NET_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [STAGE_W:0] STAGE_LIM = (STAGE_W + 1)'(STAGE_NUM);
    localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W + 1)'(1);

    logic [1:0]                           r_state;
    logic [ADDR_W-1:0]                    r_ptr;
    logic [ADDR_W:0]                      r_count;
    logic [DCNT_W-1:0]                    r_drain_cnt;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] r_r2m [CFG_DEPTH];
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] r_m2r [CFG_DEPTH];
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] r_module_select;
    logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] r_slot_select;
    logic                                 r_sel_valid;
    logic [ADDR_W-1:0]                    r_sel_idx;
    logic [NET_LAT-1:0]                   r_dv_sr;
    logic                                 r_done;

    logic w_issue;
    logic w_last;
    logic w_wr_ok;

    // Hold is combinational on the issue decision so it takes effect at the edge that samples it.
    assign w_issue = (r_state == S_RUN) && !bus.i_hold;
    assign w_last  = w_issue && (r_count == LEN_ONE);
    assign w_wr_ok = bus.i_cfg_wr_en && ({1'b0, bus.i_cfg_wr_stage} < STAGE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < CFG_DEPTH; e++) begin
                r_r2m[e] <= '0;
                r_m2r[e] <= '0;
            end
        end else if (w_wr_ok) begin
            if (bus.i_cfg_wr_tgt) begin
                r_m2r[bus.i_cfg_wr_addr][bus.i_cfg_wr_stage] <= bus.i_cfg_wr_data;
            end else begin
                r_r2m[bus.i_cfg_wr_addr][bus.i_cfg_wr_stage] <= bus.i_cfg_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_count         <= '0;
            r_drain_cnt     <= '0;
            r_module_select <= '0;
            r_slot_select   <= '0;
            r_sel_valid     <= 1'b0;
            r_sel_idx       <= '0;
            r_done          <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_sel_valid <= w_issue;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_ptr   <= bus.i_base;
                        r_count <= bus.i_len;
                        if (bus.i_len == '0) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= DCNT_W'(NET_LAT - 1);
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_module_select <= r_r2m[r_ptr];
                        r_slot_select   <= r_m2r[r_ptr];
                        r_sel_idx       <= r_ptr;
                        r_ptr           <= r_ptr + 1'b1;
                        r_count         <= r_count - 1'b1;
                        if (w_last) begin
                            // One extra count covers the select register ahead of the delay line.
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= DCNT_W'(NET_LAT);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv_sr <= '0;
        end else begin
            r_dv_sr[0] <= r_sel_valid;
            for (int i = 1; i < NET_LAT; i++) begin
                r_dv_sr[i] <= r_dv_sr[i-1];
            end
        end
    end

    assign bus.o_module_select = r_module_select;
    assign bus.o_slot_select   = r_slot_select;
    assign bus.o_sel_valid     = r_sel_valid;
    assign bus.o_sel_idx       = r_sel_idx;
    assign bus.o_data_valid    = r_dv_sr[NET_LAT-1];
    assign bus.o_busy          = (r_state != S_IDLE);
    assign bus.o_done          = r_done;
endmodule

// File: tb/tb_benes_route_sequencer.sv
// tb/tb_benes_route_sequencer.sv - table-driven replay vectors plus reset, wrap, hold and write-collision sequences
module tb_benes_route_sequencer;
    localparam int SIZE = 32;
    localparam int CFG_DEPTH = 16;
    localparam int NET_LAT = 4;
    localparam int SW = 16;
    localparam int ST = 9;
    localparam int SELW = SW * ST;

    typedef struct {
        logic [3:0]  base;
        logic [4:0]  len;
        logic [31:0] hold;
        int          restart_at;
        int          exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    benes_route_sequencer_if #(.SIZE(SIZE), .CFG_DEPTH(CFG_DEPTH)) bus ();
    benes_route_sequencer #(.SIZE(SIZE), .CFG_DEPTH(CFG_DEPTH), .NET_LAT(NET_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [ST-1:0][SW-1:0] m_r2m [CFG_DEPTH];
    logic [ST-1:0][SW-1:0] m_m2r [CFG_DEPTH];
    logic [SELW-1:0] last_r2m;
    logic [SELW-1:0] last_m2r;
    int n_vec = 0;
    int n_err = 0;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [SELW-1:0] act, input logic [SELW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int e = 0; e < CFG_DEPTH; e++) begin
            m_r2m[e] = '0;
            m_m2r[e] = '0;
        end
        last_r2m = '0;
        last_m2r = '0;
    endtask

    task automatic wr(input logic tgt, input logic [3:0] addr, input logic [3:0] stage, input logic [15:0] data);
        bus.i_cfg_wr_en = 1'b1;
        bus.i_cfg_wr_tgt = tgt;
        bus.i_cfg_wr_addr = addr;
        bus.i_cfg_wr_stage = stage;
        bus.i_cfg_wr_data = data;
        @(negedge clk);
        bus.i_cfg_wr_en = 1'b0;
        if (stage < ST) begin
            if (tgt) m_m2r[addr][stage] = data;
            else     m_r2m[addr][stage] = data;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rst_msel"}, bus.o_module_select, '0);
        chk({tag, "_rst_ssel"}, bus.o_slot_select, '0);
        chk({tag, "_rst_sv"}, SELW'(bus.o_sel_valid), '0);
        chk({tag, "_rst_idx"}, SELW'(bus.o_sel_idx), '0);
        chk({tag, "_rst_dv"}, SELW'(bus.o_data_valid), '0);
        chk({tag, "_rst_busy"}, SELW'(bus.o_busy), '0);
        chk({tag, "_rst_done"}, SELW'(bus.o_done), '0);
    endtask

    // Called at a negedge with the DUT idle; drives the start for the next edge E0 and follows the run to o_done.
    task automatic run(input string nm, input logic [3:0] base, input logic [4:0] len, input logic [31:0] hold,
                       input int restart_at, input int wr_at, input int exp_done);
        logic exp_sv [40];
        logic [3:0] eidx;
        int issued;
        int done_c;
        issued = 0;
        for (int e = 0; e < 40; e++) exp_sv[e] = 1'b0;
        for (int e = 1; e < 32; e++) begin
            if (issued < int'(len) && !hold[e]) begin
                exp_sv[e] = 1'b1;
                issued++;
            end
        end
        bus.i_start = 1'b1;
        bus.i_base = base;
        bus.i_len = len;
        bus.i_hold = 1'b0;
        issued = 0;
        done_c = -1;
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) done_c = c;
            chk($sformatf("%s_done_c%0d", nm, c), SELW'(bus.o_done), SELW'(c == exp_done));
            chk($sformatf("%s_busy_c%0d", nm, c), SELW'(bus.o_busy), SELW'(c < exp_done));
            chk($sformatf("%s_sv_c%0d", nm, c), SELW'(bus.o_sel_valid), SELW'(exp_sv[c]));
            chk($sformatf("%s_dv_c%0d", nm, c), SELW'(bus.o_data_valid), SELW'((c >= NET_LAT) ? exp_sv[c-NET_LAT] : 1'b0));
            if (exp_sv[c]) begin
                eidx = base + 4'(issued);
                issued++;
                last_r2m = m_r2m[eidx];
                last_m2r = m_m2r[eidx];
                chk($sformatf("%s_idx_c%0d", nm, c), SELW'(bus.o_sel_idx), SELW'(eidx));
            end
            chk($sformatf("%s_msel_c%0d", nm, c), bus.o_module_select, last_r2m);
            chk($sformatf("%s_ssel_c%0d", nm, c), bus.o_slot_select, last_m2r);
            if (c == wr_at) m_r2m[7][0] = 16'hBEEF;
            bus.i_start = (c + 1 == restart_at);
            bus.i_base = base + 4'd7;
            bus.i_len = 5'd1;
            bus.i_hold = (c + 1 < 32) ? hold[c+1] : 1'b0;
            bus.i_cfg_wr_en = (c + 1 == wr_at);
            bus.i_cfg_wr_tgt = 1'b0;
            bus.i_cfg_wr_addr = 4'd7;
            bus.i_cfg_wr_stage = 4'd0;
            bus.i_cfg_wr_data = 16'hBEEF;
        end
        bus.i_start = 1'b0;
        bus.i_hold = 1'b0;
        bus.i_cfg_wr_en = 1'b0;
        if (done_c < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no o_done expected o_done at cycle %0d", nm, exp_done);
        end
    endtask

    initial begin
        bus.i_cfg_wr_en = 1'b0;
        bus.i_cfg_wr_tgt = 1'b0;
        bus.i_cfg_wr_addr = '0;
        bus.i_cfg_wr_stage = '0;
        bus.i_cfg_wr_data = '0;
        bus.i_start = 1'b0;
        bus.i_base = '0;
        bus.i_len = '0;
        bus.i_hold = 1'b0;
        clear_model();

        vecs[0] = '{base: 4'd5,  len: 5'd1,  hold: 32'h0,  restart_at: -1, exp_done: 6};
        vecs[1] = '{base: 4'd14, len: 5'd3,  hold: 32'h0,  restart_at: 2,  exp_done: 8};
        vecs[2] = '{base: 4'd0,  len: 5'd0,  hold: 32'h0,  restart_at: 2,  exp_done: 4};
        vecs[3] = '{base: 4'd0,  len: 5'd4,  hold: 32'h18, restart_at: -1, exp_done: 11};
        vecs[4] = '{base: 4'd3,  len: 5'd16, hold: 32'h0,  restart_at: 9,  exp_done: 21};
        vecs[5] = '{base: 4'd15, len: 5'd2,  hold: 32'h2,  restart_at: -1, exp_done: 8};

        #2;
        check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("zero_tbl", 4'd3, 5'd1, 32'h0, -1, -1, 6);

        wr(1'b0, 4'd5, 4'd0, 16'hA5A5);
        wr(1'b1, 4'd5, 4'd8, 16'h0F0F);
        wr(1'b0, 4'd5, 4'd9, 16'hFFFF);
        wr(1'b1, 4'd5, 4'd15, 16'hFFFF);
        wr(1'b0, 4'd7, 4'd0, 16'h7777);
        for (int e = 0; e < 7; e++) begin
            for (int s = 0; s < ST; s++) begin
                wr(1'b0, 4'((e + 14) % 16), 4'(s), {4'h3, 4'((e + 14) % 16), 4'(s), 4'hA});
                wr(1'b1, 4'((e + 14) % 16), 4'(s), {4'hC, 4'((e + 14) % 16), 4'(s), 4'h5});
            end
        end

        for (int v = 0; v < 6; v++) begin
            run($sformatf("v%0d", v), vecs[v].base, vecs[v].len, vecs[v].hold,
                vecs[v].restart_at, -1, vecs[v].exp_done);
        end

        run("wr_coll", 4'd6, 5'd2, 32'h0, -1, 2, 7);
        run("wr_new", 4'd7, 5'd1, 32'h0, -1, -1, 6);

        bus.i_start = 1'b1;
        bus.i_base = 4'd0;
        bus.i_len = 5'd8;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", SELW'(bus.o_busy), SELW'(1'b1));
        chk("mid_sv", SELW'(bus.o_sel_valid), SELW'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("post_rst", 4'd3, 5'd1, 32'h0, -1, -1, 6);
        run("post_rst5", 4'd5, 5'd1, 32'h0, -1, -1, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
